// File: rtl/ps2_note_pkg.sv
// ---------------------------------------------------------------------------
// ps2_note_pkg
// Shared constants for the PS/2 note player:
//   - PS/2 set-2 make codes for the twelve "piano row" keys
//   - the break (0xF0) and extended (0xE0) prefix bytes
//   - default tone-counter width
//   - FSM state encoding used by ps2_note_player
// ---------------------------------------------------------------------------
package ps2_note_pkg;

   // Default width of half_period and of the tone counter, in clock cycles.
   localparam int HALF_PERIOD_W_DEFAULT = 21;

   // Make codes of the piano-row keys.
   localparam logic [7:0] KEY_Q           = 8'h15;
   localparam logic [7:0] KEY_W           = 8'h1D;
   localparam logic [7:0] KEY_E           = 8'h24;
   localparam logic [7:0] KEY_R           = 8'h2D;
   localparam logic [7:0] KEY_T           = 8'h2C;
   localparam logic [7:0] KEY_Y           = 8'h35;
   localparam logic [7:0] KEY_U           = 8'h3C;
   localparam logic [7:0] KEY_I           = 8'h43;
   localparam logic [7:0] KEY_O           = 8'h44;
   localparam logic [7:0] KEY_P           = 8'h4D;
   localparam logic [7:0] KEY_OPEN_BRACE  = 8'h54;
   localparam logic [7:0] KEY_CLOSE_BRACE = 8'h5B;

   // Prefix bytes.
   localparam logic [7:0] BREAK_CODE = 8'hF0;
   localparam logic [7:0] EXT_CODE   = 8'hE0;

   // key_code value meaning "no key held".
   localparam logic [7:0] NO_KEY = 8'h00;

   // FSM state encoding.
   typedef logic [1:0] state_t;
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PLAYING = 2'd1;
   localparam logic [1:0] BREAK   = 2'd2;

endpackage : ps2_note_pkg

// File: rtl/square_wave_gen.sv
// ---------------------------------------------------------------------------
// square_wave_gen
// Square-wave tone generator: tone toggles every half_period clock cycles
// while enabled.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   enable       count only while high; low forces cnt=0, tone=0 on the edge
//   half_period  cycles per half-period of the output; 0 silences the output
//   tone         square-wave output
//
// A change of half_period while running restarts the waveform (cnt=0,
// tone=0). A change seen right after a disabled cycle is not treated as a
// restart: the counter is already at zero, and restarting again would delay
// the first toggle by one extra cycle.
// ---------------------------------------------------------------------------
module square_wave_gen
   import ps2_note_pkg::*;
#(
   parameter int HALF_PERIOD_W = HALF_PERIOD_W_DEFAULT
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [HALF_PERIOD_W-1:0] half_period,
   output logic                     tone
);

   localparam logic [HALF_PERIOD_W-1:0] HP_ONE = {{(HALF_PERIOD_W-1){1'b0}}, 1'b1};

   logic [HALF_PERIOD_W-1:0] cnt_reg;
   logic [HALF_PERIOD_W-1:0] cnt_next;
   logic                     tone_reg;
   logic                     tone_next;
   logic [HALF_PERIOD_W-1:0] hp_prev_reg;
   logic                     en_prev_reg;
   logic                     hp_changed;

   assign hp_changed = en_prev_reg && (half_period != hp_prev_reg);

   always_comb begin
      cnt_next  = cnt_reg;
      tone_next = tone_reg;
      if (!enable || (half_period == '0) || hp_changed) begin
         cnt_next  = '0;
         tone_next = 1'b0;
      end else if (cnt_reg >= (half_period - HP_ONE)) begin
         // >= rather than == so a shrinking half_period can never let the
         // counter run past its terminal value.
         cnt_next  = '0;
         tone_next = ~tone_reg;
      end else begin
         cnt_next = cnt_reg + HP_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg     <= '0;
         tone_reg    <= 1'b0;
         hp_prev_reg <= '0;
         en_prev_reg <= 1'b0;
      end else begin
         cnt_reg     <= cnt_next;
         tone_reg    <= tone_next;
         hp_prev_reg <= half_period;
         en_prev_reg <= enable;
      end
   end

   assign tone = tone_reg;

endmodule : square_wave_gen

// File: rtl/ps2_note_player.sv
// ---------------------------------------------------------------------------
// ps2_note_player
// Tracks PS/2 make/break codes, holds the currently pressed key on key_code
// (looked up externally into half_period) and drives a square-wave tone.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   scan_data    received PS/2 byte
//   scan_valid   one-cycle strobe qualifying scan_data
//   half_period  tone half-period in cycles for key_code; 0 = unmapped key
//   octave_up    (only with PS2_NOTE_PLAYER_OCTAVE_EN) halves the half-period
//   key_code     currently held make code; 0x00 = none
//   note_active  high while PLAYING a mapped key
//   tone         square-wave audio output
//
// Parameters:
//   HALF_PERIOD_W  width of half_period and of the tone counter
//   RELEASE_ANY    0: only a break of the held key stops the tone;
//                  1: any break code stops it
//
// Optional feature macro: PS2_NOTE_PLAYER_OCTAVE_EN (adds octave_up).
// ---------------------------------------------------------------------------
module ps2_note_player
   import ps2_note_pkg::*;
#(
   parameter int HALF_PERIOD_W = HALF_PERIOD_W_DEFAULT,
   parameter bit RELEASE_ANY   = 1'b0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [7:0]               scan_data,
   input  logic                     scan_valid,
   input  logic [HALF_PERIOD_W-1:0] half_period,
`ifdef PS2_NOTE_PLAYER_OCTAVE_EN
   input  logic                     octave_up,
`endif
   output logic [7:0]               key_code,
   output logic                     note_active,
   output logic                     tone
);

   state_t     state_reg;
   state_t     state_next;
   state_t     ret_state_reg;
   state_t     ret_state_next;
   logic [7:0] key_code_reg;
   logic [7:0] key_code_next;

   logic                     key_change;
   logic                     octave_change;
   logic                     gen_enable;
   logic [HALF_PERIOD_W-1:0] eff_half_period;

   // ------------------------------------------------------------------
   // Make/break FSM and key latch
   // ------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      ret_state_next = ret_state_reg;
      key_code_next  = key_code_reg;
      // Extended prefix is dropped so extended keys fold onto base codes.
      if (scan_valid && (scan_data != EXT_CODE)) begin
         if (scan_data == BREAK_CODE) begin
            // Repeated 0xF0 while already in BREAK keeps the saved state.
            if (state_reg != BREAK) begin
               ret_state_next = state_reg;
               state_next     = BREAK;
            end
         end else begin
            case (state_reg)
               IDLE: begin
                  key_code_next = scan_data;
                  state_next    = PLAYING;
               end
               PLAYING: begin
                  // Typematic repeat writes the same value: no change seen.
                  key_code_next = scan_data;
               end
               BREAK: begin
                  if (((scan_data == key_code_reg) || RELEASE_ANY) &&
                      (ret_state_reg == PLAYING)) begin
                     state_next    = IDLE;
                     key_code_next = NO_KEY;
                  end else begin
                     state_next = ret_state_reg;
                  end
               end
               default: begin
                  state_next    = IDLE;
                  key_code_next = NO_KEY;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         ret_state_reg <= IDLE;
         key_code_reg  <= NO_KEY;
      end else begin
         state_reg     <= state_next;
         ret_state_reg <= ret_state_next;
         key_code_reg  <= key_code_next;
      end
   end

   assign key_change = (key_code_next != key_code_reg);

   // ------------------------------------------------------------------
   // Effective half-period (optional octave shift)
   // ------------------------------------------------------------------
`ifdef PS2_NOTE_PLAYER_OCTAVE_EN
   logic                     octave_prev_reg;
   logic [HALF_PERIOD_W-1:0] half_period_shr;

   assign half_period_shr = half_period >> 1;
   // Shifting 1 would give 0 (silence); keep 1 instead. 0 stays 0.
   assign eff_half_period = (octave_up && (half_period_shr != '0)) ?
                            half_period_shr : half_period;
   assign octave_change   = (octave_up != octave_prev_reg);

   always_ff @(posedge clk) begin
      if (reset) begin
         octave_prev_reg <= 1'b0;
      end else begin
         octave_prev_reg <= octave_up;
      end
   end
`else
   assign eff_half_period = half_period;
   assign octave_change   = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Tone generator
   // ------------------------------------------------------------------
   // Enable follows the next state so a release silences the tone on the
   // same edge that leaves PLAYING. Dropping enable for the edge on which
   // the key (or octave) changes restarts the waveform right away, since
   // the new half_period is only visible on the following cycle.
   assign gen_enable = (state_next == PLAYING) && !key_change && !octave_change;

   square_wave_gen #(
      .HALF_PERIOD_W (HALF_PERIOD_W)
   ) u_square_wave_gen (
      .clk         (clk),
      .reset       (reset),
      .enable      (gen_enable),
      .half_period (eff_half_period),
      .tone        (tone)
   );

   assign key_code    = key_code_reg;
   assign note_active = (state_reg == PLAYING) && (half_period != '0);

endmodule : ps2_note_player

// File: tb/tb_ps2_note_player.sv
// ---------------------------------------------------------------------------
// tb_ps2_note_player
// Self-checking bench for ps2_note_player: a hand-derived vector table for
// the directed scenarios, then randomized bytes checked against a reference
// model that tracks the held key and the number of cycles since the tone
// last (re)started. KeyToNote: 0x15->4, 0x2C->3, 0x3C->2, others->0.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_note_player;
   import ps2_note_pkg::*;

   localparam int HPW     = 21;
   localparam bit REL_ANY = 1'b0;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [7:0]     scan_data = 8'h00;
   logic           scan_valid = 1'b0;
   logic [HPW-1:0] half_period;
   logic           octave_up = 1'b0;
   logic [7:0]     key_code;
   logic           note_active;
   logic           tone;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   function automatic logic [HPW-1:0] key_to_note(input logic [7:0] k);
      case (k)
         8'h15:   return 21'd4;
         8'h2C:   return 21'd3;
         8'h3C:   return 21'd2;
         default: return 21'd0;
      endcase
   endfunction

   assign half_period = key_to_note(key_code);

   ps2_note_player #(
      .HALF_PERIOD_W (HPW),
      .RELEASE_ANY   (REL_ANY)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .scan_data   (scan_data),
      .scan_valid  (scan_valid),
      .half_period (half_period),
`ifdef PS2_NOTE_PLAYER_OCTAVE_EN
      .octave_up   (octave_up),
`endif
      .key_code    (key_code),
      .note_active (note_active),
      .tone        (tone)
   );

   // ---------------- reference model ----------------
   logic [7:0] m_key      = 8'h00;
   bit         m_play     = 1'b0;  // a key is latched and sounding
   bit         m_brk      = 1'b0;  // waiting for the byte after 0xF0
   bit         m_ret_play = 1'b0;  // was playing when 0xF0 arrived
   bit         m_oct_prev = 1'b0;
   int         m_k        = 0;     // cycles counted since tone (re)start

   function automatic int eff_hp(input logic [7:0] k, input bit oct);
      int hp;
      hp = int'(key_to_note(k));
`ifdef PS2_NOTE_PLAYER_OCTAVE_EN
      if (oct && (hp / 2 != 0)) hp = hp / 2;
`endif
      return hp;
   endfunction

   task automatic model_edge(input bit rst, input bit v, input logic [7:0] b, input bit oct);
      logic [7:0] old_key;
      int         hp_now;
      bit         silent;
      if (rst) begin
         m_key = 8'h00; m_play = 0; m_brk = 0; m_ret_play = 0;
         m_k = 0; m_oct_prev = 0;
         return;
      end
      old_key = m_key;
      hp_now  = eff_hp(old_key, oct);
      if (v && b != 8'hE0) begin
         if (b == 8'hF0) begin
            if (!m_brk) begin
               m_brk = 1; m_ret_play = m_play; m_play = 0;
            end
         end else if (m_brk) begin
            m_brk = 0;
            if ((b == m_key || REL_ANY) && m_ret_play) begin
               m_key = 8'h00; m_play = 0;
            end else begin
               m_play = m_ret_play;
            end
         end else begin
            m_key = b; m_play = 1;
         end
      end
      silent = !m_play || (m_key != old_key) || (hp_now == 0) || (oct != m_oct_prev);
      m_oct_prev = oct;
      m_k = silent ? 0 : m_k + 1;
   endtask

   function automatic int model_tone();
      int hp;
      hp = eff_hp(m_key, octave_up);
      if (hp == 0) return 0;
      return (m_k / hp) % 2;
   endfunction

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: drive inputs, advance, update model, compare against model.
   task automatic cycle(input bit rst, input bit v, input logic [7:0] b);
      reset = rst; scan_valid = v; scan_data = b;
      @(posedge clk); #1;
      model_edge(rst, v, b, octave_up);
      check("model key_code", int'(key_code), int'(m_key));
      check("model note_active", int'(note_active),
            int'(m_play && eff_hp(m_key, octave_up) != 0));
      check("model tone", int'(tone), model_tone());
      $display("cyc rst=%0d v=%0d b=%02h -> key=%02h act=%0d tone=%0d",
               rst, v, b, key_code, note_active, tone);
      reset = 1'b0; scan_valid = 1'b0;
   endtask

   typedef struct {
      bit         rst;
      bit         v;
      logic [7:0] b;
      logic [7:0] key;
      bit         act;
      bit         tone;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit rst, input bit v, input logic [7:0] b,
                      input logic [7:0] key, input bit act, input bit tn);
      vec_t r;
      r.rst = rst; r.v = v; r.b = b; r.key = key; r.act = act; r.tone = tn;
      vecs.push_back(r);
   endtask

   initial begin
      // 1: reset, press Q (hp 4): toggles every 4 cycles
      add(1, 0, 8'h00, 8'h00, 0, 0);
      add(0, 1, KEY_Q, 8'h15, 1, 0);
      add(0, 0, 8'h00, 8'h15, 1, 0);
      add(0, 0, 8'h00, 8'h15, 1, 0);
      add(0, 0, 8'h00, 8'h15, 1, 0);
      add(0, 0, 8'h00, 8'h15, 1, 1);
      add(0, 0, 8'h00, 8'h15, 1, 1);
      // 2: typematic repeats leave the phase alone
      add(0, 1, KEY_Q, 8'h15, 1, 1);
      add(0, 0, 8'h00, 8'h15, 1, 1);
      add(0, 1, KEY_Q, 8'h15, 1, 0);
      add(0, 1, KEY_Q, 8'h15, 1, 0);
      add(0, 0, 8'h00, 8'h15, 1, 0);
      add(0, 0, 8'h00, 8'h15, 1, 0);
      add(0, 0, 8'h00, 8'h15, 1, 1);
      // 3: press T (hp 3) over Q, then release the non-held Q
      add(0, 1, KEY_T, 8'h2C, 1, 0);
      add(0, 0, 8'h00, 8'h2C, 1, 0);
      add(0, 0, 8'h00, 8'h2C, 1, 0);
      add(0, 0, 8'h00, 8'h2C, 1, 1);
      add(0, 0, 8'h00, 8'h2C, 1, 1);
      add(0, 0, 8'h00, 8'h2C, 1, 1);
      add(0, 0, 8'h00, 8'h2C, 1, 0);
      add(0, 1, BREAK_CODE, 8'h2C, 0, 0);
      add(0, 1, KEY_Q, 8'h2C, 1, 0);
      add(0, 0, 8'h00, 8'h2C, 1, 0);
      add(0, 0, 8'h00, 8'h2C, 1, 1);
      // 4: release T, then press unmapped W
      add(0, 1, BREAK_CODE, 8'h2C, 0, 0);
      add(0, 1, KEY_T, 8'h00, 0, 0);
      add(0, 0, 8'h00, 8'h00, 0, 0);
      add(0, 1, KEY_W, 8'h1D, 0, 0);
      add(0, 0, 8'h00, 8'h1D, 0, 0);
      // 5: E0 prefix ignored, U (hp 2), reset with a byte in the same cycle
      add(0, 1, EXT_CODE, 8'h1D, 0, 0);
      add(0, 1, KEY_U, 8'h3C, 1, 0);
      add(0, 0, 8'h00, 8'h3C, 1, 0);
      add(0, 0, 8'h00, 8'h3C, 1, 1);
      add(0, 0, 8'h00, 8'h3C, 1, 1);
      add(0, 0, 8'h00, 8'h3C, 1, 0);
      add(0, 0, 8'h00, 8'h3C, 1, 0);
      add(0, 0, 8'h00, 8'h3C, 1, 1);
      add(1, 1, KEY_Q, 8'h00, 0, 0);
      add(0, 0, 8'h00, 8'h00, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         cycle(vecs[i].rst, vecs[i].v, vecs[i].b);
         check($sformatf("row%0d key_code", i), int'(key_code), int'(vecs[i].key));
         check($sformatf("row%0d note_active", i), int'(note_active), int'(vecs[i].act));
         check($sformatf("row%0d tone", i), int'(tone), int'(vecs[i].tone));
      end

      // Repeated 0xF0 stays in BREAK; the following key byte still releases.
      cycle(0, 1, KEY_U);
      cycle(0, 1, BREAK_CODE);
      cycle(0, 1, BREAK_CODE);
      check("double F0 silent", int'(tone), 0);
      cycle(0, 1, KEY_U);
      check("double F0 release", int'(key_code), 0);

      // Break from IDLE returns to IDLE without latching anything.
      cycle(0, 1, BREAK_CODE);
      cycle(0, 1, KEY_Q);
      check("idle break key", int'(key_code), 0);
      check("idle break act", int'(note_active), 0);

`ifdef PS2_NOTE_PLAYER_OCTAVE_EN
      // 6: hold Q and raise the octave: restart, then toggle every 2 cycles
      cycle(1, 0, 8'h00);
      cycle(0, 1, KEY_Q);
      for (int i = 0; i < 5; i++) cycle(0, 0, 8'h00);
      octave_up = 1'b1;
      begin
         bit exp_oct[6] = '{0, 0, 1, 1, 0, 0};
         for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 8'h00);
            check($sformatf("octave tone %0d", i), int'(tone), int'(exp_oct[i]));
         end
      end
      octave_up = 1'b0;
      cycle(0, 0, 8'h00);
      check("octave off restart", int'(tone), 0);
`endif

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         bit         r_rst;
         bit         r_v;
         logic [7:0] r_b;
         r_rst = ($urandom_range(0, 199) == 0);
         r_v   = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 9))
            0:       r_b = KEY_Q;
            1:       r_b = KEY_T;
            2:       r_b = KEY_U;
            3:       r_b = KEY_W;
            4, 5:    r_b = BREAK_CODE;
            6:       r_b = EXT_CODE;
            7:       r_b = m_key;
            8:       r_b = 8'($urandom_range(0, 255));
            default: r_b = KEY_E;
         endcase
`ifdef PS2_NOTE_PLAYER_OCTAVE_EN
         if ($urandom_range(0, 29) == 0) octave_up = ~octave_up;
`endif
         cycle(r_rst, r_v, r_b);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule : tb_ps2_note_player

// File: doc/ps2_note_player.md
Name: ps2_note_player

Overview:
- Consumes the PS/2 scan-code byte stream from the keyboard receiver and tracks make/break codes (0xF0 prefix).
- Holds the currently pressed key on key_code; key_code drives the combinational KeyToNote mapper.
- Takes KeyToNote's half_period back and generates the square-wave tone for the speaker pin.
- Sits between the PS/2 receiver and the audio output.

Parameters:
- HALF_PERIOD_W, 21: width of the half_period input and of the tone counter, in clock cycles.
- RELEASE_ANY, 0: 0 = only a break of the held key stops the tone; 1 = any break code stops it.

Ports:
- clk  input  1  system clock; one clock domain.
- reset  input  1  synchronous, active-high reset.
- scan_data  input  8  received PS/2 byte.
- scan_valid  input  1  one-cycle strobe; scan_data is valid in that cycle.
- half_period  input  HALF_PERIOD_W  cycles per tone half-period, from KeyToNote(key_code); 0 = unmapped key.
- key_code  output  8  currently held make code; 0x00 = none.
- note_active  output  1  high when state is PLAYING and half_period != 0.
- tone  output  1  square-wave audio output.

Behaviour:
- Reset, synchronous, applies the same cycle whatever the state: state=IDLE, key_code=0x00, cnt=0, tone=0, note_active=0.
- Bytes are processed only on cycles with scan_valid=1. All other inputs are ignored outside those cycles.
- States:
  - IDLE: no key held.
  - PLAYING: key latched.
  - BREAK: 0xF0 received; ret_state stores the state to return to.
- Transitions, on a valid byte b:
  - b==0xF0, from IDLE or PLAYING -> BREAK; ret_state = current state.
  - b==0xF0 while in BREAK -> stay in BREAK.
  - b==0xE0 -> ignored in every state (extended keys fold onto their base code).
  - IDLE, other b -> key_code=b, go to PLAYING.
  - PLAYING, b==key_code (typematic repeat) -> no change; counter is not restarted.
  - PLAYING, b!=key_code -> key_code=b (last-pressed wins); restart tone.
  - BREAK, b==key_code (or any b with RELEASE_ANY=1), ret_state==PLAYING -> IDLE, key_code=0x00.
  - BREAK, otherwise -> return to ret_state with key_code unchanged (release of a non-held key).
- Latency:
  - key_code updates on the cycle after the strobe.
  - half_period follows combinationally.
  - The first tone toggle occurs half_period cycles after key_code changes.
- Tone generator, cnt of HALF_PERIOD_W bits:
  - Restart (key_code change, or half_period differs from its value on the previous cycle): cnt=0, tone=0.
  - Not PLAYING, or half_period==0: cnt=0, tone=0.
  - Otherwise, if cnt >= half_period-1: cnt=0 and tone toggles. The >= compare is the guard against overrun.
  - Otherwise cnt increments.
- half_period==1 gives tone toggling every cycle (clk/2).
- Maximum half_period: 2^21-1, with no overflow because cnt never exceeds half_period-1.
- Release takes effect on the same edge as the state change: tone=0 the next cycle.
- Simultaneous reset and scan_valid: reset wins and the byte is dropped.

Optional Feature:
- Macro: PS2_NOTE_PLAYER_OCTAVE_EN.
- Defined:
  - Adds input port octave_up (1 bit).
  - Effective half period = half_period>>1 when octave_up=1, with a minimum of 1 for nonzero half_period.
  - A change of octave_up restarts the tone, the same as a half_period change.
- Undefined: no octave_up port; effective half period = half_period.

Decomposition:
- Package ps2_note_pkg:
  - Scan-code constants: KEY_Q=0x15, KEY_W=0x1D, KEY_E=0x24, KEY_R=0x2D, KEY_T=0x2C, KEY_Y=0x35, KEY_U=0x3C, KEY_I=0x43, KEY_O=0x44, KEY_P=0x4D, KEY_OPEN_BRACE=0x54, KEY_CLOSE_BRACE=0x5B.
  - Prefixes: BREAK_CODE=0xF0, EXT_CODE=0xE0.
  - Default HALF_PERIOD_W=21.
  - State encoding: IDLE/PLAYING/BREAK.
- Sub-module square_wave_gen holds the counter, toggle and restart-on-change logic, with ports clk, reset, enable, half_period, tone.
- ps2_note_player keeps the FSM and the key latch.

Test Plan (bench models KeyToNote as: 0x15->4, 0x2C->3, 0x3C->2, others->0):
1. Reset, then strobe 0x15 -> key_code=0x15 next cycle; note_active=1; tone toggles every 4 cycles (period 8); cnt restarts on the change.
2. Holding Q, strobe 0x15 three more times (typematic) -> tone phase undisturbed, with no restart glitch.
3. Holding Q, strobe 0x2C -> key_code=0x2C; tone=0 on the next cycle, then toggles every 3 cycles. Then strobe 0xF0, 0x15 (release of a non-held key) -> still PLAYING 0x2C.
4. Strobe 0xF0, 0x2C -> key_code=0x00, note_active=0, tone held 0. Strobe 0x1D (unmapped, hp=0) -> PLAYING with note_active=0 and tone=0.
5. Strobe 0xE0, 0x3C -> key_code=0x3C, toggling every 2 cycles. Assert reset mid-tone while tone=1 -> next cycle: IDLE, key_code=0, tone=0, and the byte strobed in the reset cycle is dropped.
6. With PS2_NOTE_PLAYER_OCTAVE_EN, hold 0x15 and set octave_up=1 -> tone restarts and toggles every 2 cycles.
